fp16_acc_seq: RTL and testbench
===============================

Name: fp16_acc_seq

Overview:
Multi-cycle IEEE-754 binary16 accumulator that sits directly downstream of the combinational fp16 multiplier (mpy_top).
It consumes a stream of fp16 products over a valid/ready handshake and sums them into a running fp16 accumulator, one term per 4-cycle add.
On the term flagged last, it presents the rounded sum on an output handshake, then clears for the next vector.
Together with mpy_top it forms the dot-product datapath.

Parameters:
CNT_W, 8, width of term counter; counter saturates at 2^CNT_W-1

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  product word valid
in_ready  output  1  block can accept a term this cycle
in_data  input  16  fp16 term (sign, exp[14:10], frac[9:0])
in_last  input  1  term is final of the vector; sampled with in_data
out_valid  output  1  accumulated result valid
out_ready  input  1  consumer accepts result
out_data  output  16  fp16 accumulated sum
out_cnt  output  CNT_W  number of terms summed into out_data (saturating)

Behaviour:
- Reset (async assert, sync release): state=IDLE, acc=16'h0000, cnt=0, last flag=0, in_ready=1, out_valid=0, out_data=16'h0000, out_cnt=0.
- FSM: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> (IDLE | OUT).
- IDLE: in_ready=1. On in_valid&&in_ready, register in_data and in_last, go to ALIGN. in_ready is 0 in every other state.
- ALIGN: unpack both operands (subnormal: hidden bit 0, exponent 1). Right-shift the smaller-magnitude mantissa by the exponent difference. Keep guard, round and sticky bits; shifts >=14 collapse to sticky.
- ADD: signed-magnitude add/subtract on 14-bit extended mantissas; record the result sign.
- NORM: left- or right-normalise. Exponent floor is 1; below it, the result stays subnormal.
- ROUND: round-to-nearest-even, pack, write acc, cnt=cnt+1 (saturating). Go to OUT if the last flag is set, else IDLE.
- Latency: term accepted at edge T -> acc updated at edge T+4 -> in_ready high again at T+4 (non-last). For a last term, out_valid rises at T+4.
- OUT: out_valid=1; out_data=acc and out_cnt=cnt, held stable until out_valid&&out_ready. On that edge: acc=0000, cnt=0, out_valid=0, go to IDLE.
- Special values:
  - Exact cancellation -> +0 (16'h0000).
  - (+0)+(-0) -> +0; (-0)+(-0) -> 8000.
  - Exponent overflow after rounding -> +/-inf (7C00/FC00).
  - Any NaN operand, or inf + -inf -> canonical NaN 7E00; NaN is sticky for the rest of the vector.
  - inf + finite -> inf.
- A single-term vector returns the term itself, with NaN canonicalised.
- in_valid while in_ready=0 is ignored (the producer holds the term).
- Reset mid-operation: in any state, rst_n low returns to reset values immediately. The partial sum and pending output are discarded.

Decomposition:
- Package fp16_pkg:
  - Widths: EXP_W=5, FRAC_W=10, EXT_W=14.
  - EXP_BIAS=15.
  - Constants: FP16_QNAN=16'h7E00, FP16_PINF=16'h7C00, FP16_NINF=16'hFC00, FP16_PZERO=16'h0000.
  - State enum: IDLE, ALIGN, ADD, NORM, ROUND, OUT.
  - Unpacked-operand struct: sign, exp, ext mantissa, is_zero, is_inf, is_nan.
- One combinational sub-module, fp16_round_pack: normalised sign/exp/mantissa+GRS in, RNE-rounded fp16 word out, with overflow to inf. It is instantiated in the ROUND state datapath.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, in_data=3C00 -> in_ready=1, out_valid=0, out_data=0000, out_cnt=0; no term accepted.
- Basic sum: 3C00, 3C00(last) -> out_data=4000, out_cnt=2. out_valid rises exactly 4 cycles after the last accept; in_ready is 0 during ALIGN..ROUND.
- Rounding ties: 3C00 + 1000(last) -> 3C00 (tie to even, down); 3C01 + 1000(last) -> 3C02 (tie to even, up).
- Specials:
  - 3C00 + BC00(last) -> 0000.
  - 7BFF + 7BFF(last) -> 7C00.
  - 7C00 + FC00(last) -> 7E00.
  - 7E00 + 3C00 + 3C00(last) -> 7E00.
  - Subnormals: 0001 + 0001(last) -> 0002; 03FF + 0001(last) -> 0400.
- Backpressure: after result 4000 is ready, hold out_ready=0 for 3 cycles -> out_valid and out_data stay stable, in_ready=0. Raise out_ready -> next cycle out_valid=0, in_ready=1, and the next vector 4000(last) -> 4000, out_cnt=1.
- Reset mid-operation: assert rst_n=0 during the NORM state of the second term -> all outputs return to reset values. A following 3C00(last) -> 3C00, out_cnt=1.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared fp16 formats, FSM encodings and operand unpacking for the fp16 accumulator.
package fp16_pkg;

  localparam int EXP_W    = 5;
  localparam int FRAC_W   = 10;
  localparam int EXT_W    = 14;
  localparam int EXP_BIAS = 15;

  localparam logic [15:0] FP16_QNAN  = 16'h7E00;
  localparam logic [15:0] FP16_PINF  = 16'h7C00;
  localparam logic [15:0] FP16_NINF  = 16'hFC00;
  localparam logic [15:0] FP16_PZERO = 16'h0000;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ALIGN = 3'd1;
  localparam logic [2:0] ADD   = 3'd2;
  localparam logic [2:0] NORM  = 3'd3;
  localparam logic [2:0] ROUND = 3'd4;
  localparam logic [2:0] OUT   = 3'd5;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [EXT_W-1:0] mant;
    logic             isZero;
    logic             isInf;
    logic             isNan;
  } fp16_unpacked_t;

  // Extended mantissa layout: hidden bit, 10 fraction bits, then guard/round/sticky.
  function automatic fp16_unpacked_t unpack(input logic [15:0] w);
    fp16_unpacked_t u;
    u.sign   = w[15];
    u.exp    = (w[14:10] == 5'd0) ? 5'd1 : w[14:10];
    u.mant   = {(w[14:10] != 5'd0), w[9:0], 3'b000};
    u.isZero = (w[14:0] == 15'd0);
    u.isInf  = (w[14:10] == 5'h1F) && (w[9:0] == 10'd0);
    u.isNan  = (w[14:10] == 5'h1F) && (w[9:0] != 10'd0);
    return u;
  endfunction

  function automatic logic [3:0] lzc14(input logic [13:0] m);
    logic [3:0] n;
    n = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (m[i]) n = 4'(13 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fp16_round_pack.sv
// Round-to-nearest-even and pack of a normalised fp16 result, saturating to infinity on overflow.
module fp16_round_pack
  import fp16_pkg::*;
(
  input  logic        sign_i,
  input  logic [5:0]  exp_i,
  input  logic [13:0] mant_i,
  output logic [15:0] word_o
);

  logic        roundUp;
  logic [5:0]  expField;
  logic [15:0] packed_w;

  // A mantissa carry ripples straight into the exponent field, which also promotes subnormals.
  always_comb begin
    roundUp  = mant_i[2] & (mant_i[1] | mant_i[0] | mant_i[3]);
    expField = mant_i[13] ? exp_i : 6'd0;
    packed_w = {expField, mant_i[12:3]} + {15'd0, roundUp};
    if (packed_w[15:10] >= 6'd31) begin
      word_o = {sign_i, FP16_PINF[14:0]};
    end else begin
      word_o = {sign_i, packed_w[14:0]};
    end
  end

endmodule

// File: rtl/fp16_acc_seq.sv
// Multi-cycle fp16 accumulator: sums a stream of fp16 terms, one 4-cycle add per term,
// and presents the rounded sum and term count on an output handshake after the last term.
module fp16_acc_seq
  import fp16_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [15:0]      in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [15:0]      out_data_o,
  output logic [CNT_W-1:0] out_cnt_o
);

  logic [2:0]       state_q, state_d;
  logic [15:0]      acc_q, acc_d, term_q, term_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             bigSign_q, bigSign_d, effSub_q, effSub_d;
  logic [5:0]       bigExp_q, bigExp_d;
  logic [13:0]      bigMant_q, bigMant_d, smallMant_q, smallMant_d;
  logic             special_q, special_d;
  logic [15:0]      specialWord_q, specialWord_d;
  logic [14:0]      sum_q, sum_d;
  logic             resSign_q, resSign_d;
  logic [5:0]       normExp_q, normExp_d;
  logic [13:0]      normMant_q, normMant_d;

  fp16_unpacked_t   opA, opB;
  logic             bigSign, smallSign;
  logic [4:0]       bigExp, smallExp, expDiff;
  logic [13:0]      bigMant, smallMant, shifted, lostMask;
  logic [3:0]       lz;
  logic [5:0]       shl;
  logic [15:0]      roundWord;

  fp16_round_pack u_round_pack (
    .sign_i (resSign_q),
    .exp_i  (normExp_q),
    .mant_i (normMant_q),
    .word_o (roundWord)
  );

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == OUT);
  assign out_data_o  = acc_q;
  assign out_cnt_o   = cnt_q;

  // The first term of a vector sees a zero accumulator of its own sign, so a lone -0 survives.
  always_comb begin
    opA = unpack(acc_q);
    if (cnt_q == '0) opA.sign = term_q[15];
    opB = unpack(term_q);
    if ({opA.exp, opA.mant} >= {opB.exp, opB.mant}) begin
      bigSign = opA.sign;  bigExp = opA.exp;  bigMant = opA.mant;
      smallSign = opB.sign; smallExp = opB.exp; smallMant = opB.mant;
    end else begin
      bigSign = opB.sign;  bigExp = opB.exp;  bigMant = opB.mant;
      smallSign = opA.sign; smallExp = opA.exp; smallMant = opA.mant;
    end
    expDiff  = bigExp - smallExp;
    lostMask = ~(14'h3FFF << expDiff);
    if (expDiff >= 5'd14) begin
      shifted = {13'd0, |smallMant};
    end else begin
      shifted    = smallMant >> expDiff;
      shifted[0] = shifted[0] | (|(smallMant & lostMask));
    end
    lz  = lzc14(sum_q[13:0]);
    shl = ({2'b00, lz} < (bigExp_q - 6'd1)) ? {2'b00, lz} : (bigExp_q - 6'd1);
  end

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    term_d        = term_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    bigSign_d     = bigSign_q;
    effSub_d      = effSub_q;
    bigExp_d      = bigExp_q;
    bigMant_d     = bigMant_q;
    smallMant_d   = smallMant_q;
    special_d     = special_q;
    specialWord_d = specialWord_q;
    sum_d         = sum_q;
    resSign_d     = resSign_q;
    normExp_d     = normExp_q;
    normMant_d    = normMant_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          term_d  = in_data_i;
          last_d  = in_last_i;
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        bigSign_d   = bigSign;
        effSub_d    = bigSign ^ smallSign;
        bigExp_d    = {1'b0, bigExp};
        bigMant_d   = bigMant;
        smallMant_d = shifted;
        special_d   = opA.isNan | opB.isNan | opA.isInf | opB.isInf | (opA.isZero & opB.isZero);
        if (opA.isNan || opB.isNan || (opA.isInf && opB.isInf && (opA.sign != opB.sign))) begin
          specialWord_d = FP16_QNAN;
        end else if (opA.isInf) begin
          specialWord_d = opA.sign ? FP16_NINF : FP16_PINF;
        end else if (opB.isInf) begin
          specialWord_d = opB.sign ? FP16_NINF : FP16_PINF;
        end else begin
          specialWord_d = {opA.sign & opB.sign, FP16_PZERO[14:0]};
        end
        state_d = ADD;
      end
      ADD: begin
        if (effSub_q) sum_d = {1'b0, bigMant_q} - {1'b0, smallMant_q};
        else          sum_d = {1'b0, bigMant_q} + {1'b0, smallMant_q};
        resSign_d = (effSub_q && (bigMant_q == smallMant_q)) ? 1'b0 : bigSign_q;
        state_d   = NORM;
      end
      NORM: begin
        if (sum_q[14]) begin
          normMant_d = {sum_q[14:2], sum_q[1] | sum_q[0]};
          normExp_d  = bigExp_q + 6'd1;
        end else begin
          normMant_d = sum_q[13:0] << shl;
          normExp_d  = bigExp_q - shl;
        end
        state_d = ROUND;
      end
      ROUND: begin
        acc_d   = special_q ? specialWord_q : roundWord;
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        state_d = last_q ? OUT : IDLE;
      end
      OUT: begin
        if (out_ready_i) begin
          acc_d   = FP16_PZERO;
          cnt_d   = '0;
          last_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      acc_q         <= FP16_PZERO;
      term_q        <= 16'd0;
      cnt_q         <= '0;
      last_q        <= 1'b0;
      bigSign_q     <= 1'b0;
      effSub_q      <= 1'b0;
      bigExp_q      <= 6'd1;
      bigMant_q     <= 14'd0;
      smallMant_q   <= 14'd0;
      special_q     <= 1'b0;
      specialWord_q <= 16'd0;
      sum_q         <= 15'd0;
      resSign_q     <= 1'b0;
      normExp_q     <= 6'd1;
      normMant_q    <= 14'd0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      term_q        <= term_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      bigSign_q     <= bigSign_d;
      effSub_q      <= effSub_d;
      bigExp_q      <= bigExp_d;
      bigMant_q     <= bigMant_d;
      smallMant_q   <= smallMant_d;
      special_q     <= special_d;
      specialWord_q <= specialWord_d;
      sum_q         <= sum_d;
      resSign_q     <= resSign_d;
      normExp_q     <= normExp_d;
      normMant_q    <= normMant_d;
    end
  end

endmodule

// File: tb/tb_fp16_acc_seq.sv
// Scoreboard bench for fp16_acc_seq: directed vectors push expected sums, a monitor checks each result.
module tb_fp16_acc_seq;

  logic        clk = 1'b0;
  logic        rstN;
  logic        inValid, inReady, inLast;
  logic        outValid, outReady;
  logic [15:0] inData, outData;
  logic [7:0]  outCnt;
  logic [23:0] expQ[$];
  logic [23:0] expHead;
  int          testsRun = 0;
  int          testsFailed = 0;

  always #5 clk = ~clk;

  fp16_acc_seq #(.CNT_W(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady),
    .in_data_i   (inData),
    .in_last_i   (inLast),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .out_data_o  (outData),
    .out_cnt_o   (outCnt)
  );

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic expectResult(input logic [15:0] d, input logic [7:0] c);
    expQ.push_back({d, c});
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic l);
    int n = 0;
    inValid = 1'b1;
    inData  = d;
    inLast  = l;
    while (!inReady && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!inReady) checkOutput("acceptTimeout", {15'd0, inReady}, 16'd1);
    else begin
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drainPending", 16'(expQ.size()), 16'd0);
  endtask

  task automatic runPair(input logic [15:0] a, input logic [15:0] b, input logic [15:0] sum);
    expectResult(sum, 8'd2);
    applyStimulus(a, 1'b0);
    applyStimulus(b, 1'b1);
    waitDrain();
  endtask

  // Monitor: every completed output handshake consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rstN && outValid && outReady) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpectedResult: got %h, expected none", outData);
      end else begin
        expHead = expQ.pop_front();
        checkOutput("resultData", outData, expHead[23:8]);
        checkOutput("resultCnt", {8'd0, outCnt}, {8'd0, expHead[7:0]});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN = 1'b0; inValid = 1'b1; inData = 16'h3C00; inLast = 1'b1; outReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetReady", {15'd0, inReady}, 16'd1);
    checkOutput("resetValid", {15'd0, outValid}, 16'd0);
    checkOutput("resetData", outData, 16'h0000);
    checkOutput("resetCnt", {8'd0, outCnt}, 16'd0);
    inValid = 1'b0; inLast = 1'b0; rstN = 1'b1;
    @(posedge clk); #1;
    checkOutput("postResetCnt", {8'd0, outCnt}, 16'd0);

    // Basic sum with latency and backpressure checks.
    outReady = 1'b0;
    expectResult(16'h4000, 8'd2);
    applyStimulus(16'h3C00, 1'b0);
    applyStimulus(16'h3C00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("busyReady", {15'd0, inReady}, 16'd0);
      checkOutput("earlyValid", {15'd0, outValid}, 16'd0);
      @(posedge clk); #1;
    end
    checkOutput("latencyValid", {15'd0, outValid}, 16'd1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("holdValid", {15'd0, outValid}, 16'd1);
      checkOutput("holdData", outData, 16'h4000);
      checkOutput("holdReady", {15'd0, inReady}, 16'd0);
      @(posedge clk); #1;
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    checkOutput("releaseValid", {15'd0, outValid}, 16'd0);
    checkOutput("releaseReady", {15'd0, inReady}, 16'd1);
    expectResult(16'h4000, 8'd1);
    applyStimulus(16'h4000, 1'b1);
    waitDrain();

    runPair(16'h3C00, 16'h1000, 16'h3C00);
    runPair(16'h3C01, 16'h1000, 16'h3C02);
    runPair(16'h3C00, 16'hBC00, 16'h0000);
    runPair(16'h7BFF, 16'h7BFF, 16'h7C00);
    runPair(16'h7C00, 16'hFC00, 16'h7E00);
    runPair(16'h0001, 16'h0001, 16'h0002);
    runPair(16'h03FF, 16'h0001, 16'h0400);
    runPair(16'h8000, 16'h8000, 16'h8000);
    runPair(16'h0000, 16'h8000, 16'h0000);
    runPair(16'h7C00, 16'h3C00, 16'h7C00);

    expectResult(16'h7E00, 8'd3);
    applyStimulus(16'h7E00, 1'b0);
    applyStimulus(16'h3C00, 1'b0);
    applyStimulus(16'h3C00, 1'b1);
    waitDrain();

    expectResult(16'h0000, 8'd3);
    applyStimulus(16'h3C00, 1'b0);
    applyStimulus(16'h4000, 1'b0);
    applyStimulus(16'hC200, 1'b1);
    waitDrain();

    expectResult(16'h7E00, 8'd1);
    applyStimulus(16'h7E01, 1'b1);
    waitDrain();

    // Reset while the second term sits in NORM discards the partial sum.
    applyStimulus(16'h3C00, 1'b0);
    applyStimulus(16'h3C00, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    checkOutput("partialAcc", outData, 16'h3C00);
    checkOutput("partialCnt", {8'd0, outCnt}, 16'd1);
    rstN = 1'b0;
    #1;
    checkOutput("midResetReady", {15'd0, inReady}, 16'd1);
    checkOutput("midResetValid", {15'd0, outValid}, 16'd0);
    checkOutput("midResetData", outData, 16'h0000);
    checkOutput("midResetCnt", {8'd0, outCnt}, 16'd0);
    @(posedge clk); #1;
    rstN = 1'b1;
    expectResult(16'h3C00, 8'd1);
    applyStimulus(16'h3C00, 1'b1);
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
